// File: rtl/mem_ctrl.sv
// Memory controller: 2^ADDR_W x 16 RAM plus keyboard/display registers,
// reached through a fixed-latency CS/ready handshake.
module mem_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CS,
   input  logic        WE,
   input  logic [15:0] ADDR,
   input  logic [15:0] DataIn,
   output logic [15:0] out,
   output logic        ready,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        kb_ack,
   output logic        disp_valid,
   output logic [7:0]  disp_data,
   input  logic        disp_ready
);

   // state | meaning
   // IDLE  | waiting for CS; request fields latched when leaving
   // BUSY  | latency countdown; request inputs ignored
   // DONE  | access performed, ready strobe
   // HOLD  | access finished, waiting for CS to drop
   typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

   localparam logic [15:0] KBSR_A   = 16'hFE00;
   localparam logic [15:0] KBDR_A   = 16'hFE02;
   localparam logic [15:0] DSR_A    = 16'hFE04;
   localparam logic [15:0] DDR_A    = 16'hFE06;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        cnt_tc;
   logic        we_q;
   logic [15:0] addr_q;
   logic [15:0] din_q;
   logic        kb_flag;
   logic [7:0]  kbdr;
   logic [15:0] mem [2**ADDR_W];
   logic        ram_hit;
   logic        rd_load;
   logic        wr_done;
   logic        kbdr_rd_done;
   logic        ddr_wr_done;
   logic [15:0] rd_data;

   assign cnt_tc       = (cnt == 4'd0);
   assign ram_hit      = ((addr_q >> ADDR_W) == 16'd0);
   assign rd_load      = (state == BUSY) && cnt_tc && !we_q;
   assign wr_done      = (state == DONE) && we_q;
   assign kbdr_rd_done = (state == DONE) && !we_q && !ram_hit && (addr_q == KBDR_A);
   assign ddr_wr_done  = wr_done && !ram_hit && (addr_q == DDR_A);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: if (CS) state_nxt = BUSY;
         BUSY: if (cnt_tc) state_nxt = DONE;
         DONE: begin
            ready     = 1'b1;
            state_nxt = CS ? HOLD : IDLE;
         end
         HOLD: if (!CS) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is sampled on the last BUSY edge so it is stable during DONE.
   always_comb begin
      rd_data = 16'h0000;
      if (ram_hit) begin
         rd_data = mem[addr_q[ADDR_W-1:0]];
      end else begin
         case (addr_q)
            KBSR_A:  rd_data = {kb_flag, 15'b0};
            KBDR_A:  rd_data = {8'b0, kbdr};
            DSR_A:   rd_data = {~disp_valid, 15'b0};
            default: rd_data = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && wr_done && ram_hit) mem[addr_q[ADDR_W-1:0]] <= din_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= 16'h0000;
         din_q      <= 16'h0000;
         out        <= 16'h0000;
         kb_flag    <= 1'b0;
         kbdr       <= 8'h00;
         kb_ack     <= 1'b0;
         disp_valid <= 1'b0;
         disp_data  <= 8'h00;
      end else begin
         kb_ack <= 1'b0;

         if (state == IDLE && CS) begin
            we_q   <= WE;
            addr_q <= ADDR;
            din_q  <= DataIn;
            cnt    <= CNT_LOAD;
         end else if (state == BUSY && !cnt_tc) begin
            cnt <= cnt - 4'd1;
         end

         if (rd_load) out <= rd_data;

         // A KBDR read completing wins over a byte arriving in the same cycle.
         if (kbdr_rd_done) begin
            kb_flag <= 1'b0;
         end else if (kb_valid && !kb_flag) begin
            kb_flag <= 1'b1;
            kbdr    <= kb_data;
            kb_ack  <= 1'b1;
         end

         if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
         end else if (ddr_wr_done && !disp_valid) begin
            disp_valid <= 1'b1;
            disp_data  <= din_q[7:0];
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: reads push expected data, a negedge monitor
// pops one entry per ready strobe and compares out.
module tb_mem_ctrl;
   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        RST, CS, WE;
   logic [15:0] ADDR, DataIn, out;
   logic        ready, kb_valid, kb_ack, disp_valid, disp_ready;
   logic [7:0]  kb_data, disp_data;

   int tests = 0;
   int fails = 0;
   int kb_ack_cnt = 0;

   typedef struct {
      logic        is_rd;
      logic [15:0] val;
      logic [15:0] addr;
   } sb_t;
   sb_t sb_q[$];

   always #5 CLK = ~CLK;

   mem_ctrl #(.ADDR_W(12), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
      .out(out), .ready(ready), .kb_valid(kb_valid), .kb_data(kb_data),
      .kb_ack(kb_ack), .disp_valid(disp_valid), .disp_data(disp_data),
      .disp_ready(disp_ready)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (kb_ack) kb_ack_cnt++;
      if (ready) begin
         sb_t e;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: ready high with no access outstanding at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            if (e.is_rd) chk($sformatf("read_%h", e.addr), out, e.val);
         end
      end
   end

   task automatic wait_ready(input int n0, output int n);
      n = n0;
      @(negedge CLK);
      while (!ready && n < 40) begin
         @(negedge CLK);
         n++;
      end
      if (!ready && sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
   endtask

   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp);
      int n;
      @(posedge CLK); #1;
      CS = 1'b1; WE = w; ADDR = a; DataIn = d;
      sb_q.push_back('{is_rd: !w, val: exp, addr: a});
      @(posedge CLK); #1;
      ADDR = ~a; DataIn = ~d; WE = ~w;
      wait_ready(1, n);
      chk($sformatf("latency_%h", a), 16'(n), 16'(LAT + 1));
      @(posedge CLK); #1;
      CS = 1'b0; WE = 1'b0; ADDR = 16'h0000; DataIn = 16'h0000;
      @(posedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int ack0;
      RST = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = 16'h0000; DataIn = 16'h0000;
      kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_out", out, 16'h0000);
      chk("rst_ready", 16'(ready), 16'h0000);
      chk("rst_kb_ack", 16'(kb_ack), 16'h0000);
      chk("rst_disp_valid", 16'(disp_valid), 16'h0000);
      chk("rst_disp_data", 16'(disp_data), 16'h0000);

      // RAM write then read back
      access(1'b1, 16'h0010, 16'h1234, 16'h0000);
      access(1'b0, 16'h0010, 16'h0000, 16'h1234);

      // CS held through HOLD gives one ready; one low cycle re-arms
      @(posedge CLK); #1;
      CS = 1'b1; WE = 1'b0; ADDR = 16'h0010;
      sb_q.push_back('{is_rd: 1'b1, val: 16'h1234, addr: 16'h0010});
      wait_ready(0, n);
      chk("hold_latency", 16'(n), 16'(LAT + 1));
      n = 0;
      repeat (3) @(negedge CLK) if (ready) n++;
      chk("hold_extra_ready", 16'(n), 16'h0000);
      @(posedge CLK); #1;
      CS = 1'b0;
      access(1'b0, 16'h0010, 16'h0000, 16'h1234);

      // top RAM word; write leaves out alone
      access(1'b1, 16'h0FFF, 16'hBEEF, 16'h0000);
      chk("write_keeps_out", out, 16'h1234);
      access(1'b0, 16'h0FFF, 16'h0000, 16'hBEEF);

      // unmapped: write discarded (no aliasing), reads return zero
      access(1'b1, 16'h2010, 16'hDEAD, 16'h0000);
      access(1'b0, 16'h0010, 16'h0000, 16'h1234);
      access(1'b0, 16'h1000, 16'h0000, 16'h0000);

      // keyboard capture
      ack0 = kb_ack_cnt;
      @(posedge CLK); #1;
      kb_valid = 1'b1; kb_data = 8'h41;
      repeat (4) @(posedge CLK);
      #1 kb_valid = 1'b0;
      repeat (2) @(posedge CLK);
      chk("kb_ack_once", 16'(kb_ack_cnt - ack0), 16'h0001);
      access(1'b0, 16'hFE00, 16'h0000, 16'h8000);
      access(1'b0, 16'hFE02, 16'h0000, 16'h0041);
      access(1'b0, 16'hFE00, 16'h0000, 16'h0000);

      // KBDR read clearing the flag while kb_valid stays high
      ack0 = kb_ack_cnt;
      @(posedge CLK); #1;
      kb_valid = 1'b1; kb_data = 8'h42;
      repeat (2) @(posedge CLK);
      #1 kb_data = 8'h43;
      access(1'b0, 16'hFE02, 16'h0000, 16'h0042);
      #1 kb_valid = 1'b0;
      access(1'b0, 16'hFE00, 16'h0000, 16'h8000);
      access(1'b0, 16'hFE02, 16'h0000, 16'h0043);
      access(1'b0, 16'hFE00, 16'h0000, 16'h0000);
      chk("kb_ack_twice", 16'(kb_ack_cnt - ack0), 16'h0002);

      // status register write is discarded
      access(1'b1, 16'hFE00, 16'hFFFF, 16'h0000);
      access(1'b0, 16'hFE00, 16'h0000, 16'h0000);

      // display
      access(1'b1, 16'hFE06, 16'h0048, 16'h0000);
      n = 0;
      repeat (5) @(negedge CLK) if (disp_valid) n++;
      chk("disp_valid_held", 16'(n), 16'h0005);
      chk("disp_data", 16'(disp_data), 16'h0048);
      access(1'b0, 16'hFE04, 16'h0000, 16'h0000);
      access(1'b1, 16'hFE06, 16'h0055, 16'h0000);
      chk("disp_data_dropped", 16'(disp_data), 16'h0048);
      access(1'b0, 16'hFE06, 16'h0000, 16'h0000);
      @(posedge CLK); #1;
      disp_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("disp_valid_cleared", 16'(disp_valid), 16'h0000);
      #1 disp_ready = 1'b0;
      access(1'b0, 16'hFE04, 16'h0000, 16'h8000);

      // reset in the middle of a write
      access(1'b1, 16'h0020, 16'hA5A5, 16'h0000);
      access(1'b0, 16'h0020, 16'h0000, 16'hA5A5);
      @(posedge CLK); #1;
      kb_valid = 1'b1; kb_data = 8'h77;
      @(posedge CLK); #1;
      kb_valid = 1'b0;
      CS = 1'b1; WE = 1'b1; ADDR = 16'h0020; DataIn = 16'h5555;
      @(posedge CLK); #1;
      RST = 1'b1; CS = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      n = 0;
      repeat (10) @(negedge CLK) if (ready) n++;
      chk("rst_abort_no_ready", 16'(n), 16'h0000);
      chk("rst_abort_out", out, 16'h0000);
      access(1'b0, 16'hFE00, 16'h0000, 16'h0000);
      access(1'b0, 16'h0020, 16'h0000, 16'hA5A5);
      access(1'b0, 16'hC000, 16'h0000, 16'h0000);

      repeat (5) @(posedge CLK);
      chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: internal RAM holds 2^ADDR_W 16-bit words.
REQ-002 Parameter LATENCY, default 3: BUSY cycles per access, legal range 1..15.
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port CS  input  1  access request from control FSM (MIO_EN); held high until ready seen.
REQ-006 Port WE  input  1  1 = write, 0 = read; sampled with CS in IDLE.
REQ-007 Port ADDR  input  16  word address from MAR.
REQ-008 Port DataIn  input  16  write data from MDR.
REQ-009 Port out  output  16  read data to MEM_MUX.
REQ-010 Port ready  output  1  one-cycle access-complete strobe (R to FSM).
REQ-011 Port kb_valid  input  1  keyboard byte available.
REQ-012 Port kb_data  input  8  keyboard byte.
REQ-013 Port kb_ack  output  1  one-cycle strobe, byte captured.
REQ-014 Port disp_valid  output  1  display byte pending.
REQ-015 Port disp_data  output  8  display byte.
REQ-016 Port disp_ready  input  1  display accepts byte when high with disp_valid.

Function
REQ-017 FSM states IDLE, BUSY, DONE, HOLD; IDLE->BUSY when CS=1, latching ADDR, DataIn, WE, counter loaded LATENCY-1.
REQ-018 BUSY: counter decrements each cycle; at 0 -> DONE; CS/ADDR/DataIn/WE changes during BUSY ignored.
REQ-019 DONE: access performed, ready=1 for exactly this cycle; next state HOLD if CS=1, else IDLE.
REQ-020 HOLD: ready=0, no access; -> IDLE when CS=0; back-to-back accesses need CS low for >=1 cycle.
REQ-021 Latency: CS rising in IDLE at cycle t -> ready high at cycle t+LATENCY+1.
REQ-022 Address map: ADDR < 2^ADDR_W -> RAM; xFE00 KBSR; xFE02 KBDR; xFE04 DSR; xFE06 DDR; all else unmapped.
REQ-023 RAM read: out = mem[ADDR], valid when ready=1, held until next completed read.
REQ-024 RAM write: mem[ADDR] = DataIn at DONE edge; out unchanged.
REQ-025 Unmapped read returns x0000; unmapped write discarded; ready still pulses.
REQ-026 KB flag: set, kb_data captured into KBDR, kb_ack=1 one cycle, when kb_valid=1 and flag=0; kb_valid ignored while flag=1.
REQ-027 KBSR read = {flag,15'b0}; KBDR read = {8'b0,KBDR} and clears flag at DONE.
REQ-028 KBDR read DONE coinciding with new kb_valid: clear wins; byte captured no earlier than next cycle.
REQ-029 DSR read = {~disp_valid,15'b0}.
REQ-030 DDR write with disp_valid=0: disp_data=DataIn[7:0], disp_valid=1 from next cycle until disp_ready=1 handshake, then 0.
REQ-031 DDR write while disp_valid=1: byte dropped, disp_data unchanged, ready still pulses.
REQ-032 Writes to KBSR, KBDR, DSR discarded; reads of DDR return x0000.

Reset
REQ-033 RST=1 at a rising edge: state IDLE, counter 0, out=x0000, ready=0, kb_ack=0, KB flag 0, KBDR x00, disp_valid=0, disp_data x00.
REQ-034 RST mid-access aborts it: no RAM/DDR write, no ready pulse; RAM contents not reset.
REQ-035 RST has priority over every other event in the same cycle.

Verification
REQ-036 Write x1234 to x0010, then read x0010 with LATENCY=3 -> ready 4 cycles after CS rise each time, out=x1234.
REQ-037 CS held high 3 cycles after ready -> exactly one ready pulse; CS low 1 cycle then high -> second access starts.
REQ-038 kb_valid=1, kb_data=x41 -> kb_ack 1 cycle; KBSR read=x8000; KBDR read=x0041; KBSR read=x0000.
REQ-039 Write x0048 to xFE06, disp_ready=0 for 5 cycles -> disp_valid=1, disp_data=x48, DSR read=x0000; disp_ready=1 -> disp_valid=0, DSR read=x8000.
REQ-040 RST asserted in BUSY of write x5555 to x0020 -> no ready; later read x0020 returns prior value; read xC000 -> x0000.
